// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe
//   Parametrised VGA raster timing generator with a latency-matched pixel
//   pipeline. Scaled pixel coordinates go out to a renderer together with
//   o_req; the renderer's colour comes back PIPE_LAT clocks later. Sync and
//   blanking travel through a delay line of the same depth, so colour and
//   sync reach the DAC pins aligned. Counter state to pins is PIPE_LAT+1 clocks.
//
//   Optional build macro: VGA_FRAME_COUNTER_EN adds o_frame_cnt, a 16-bit
//   count of o_frame_start pulses.
//
// Ports
//   i_clk          pixel clock
//   i_rst_n        synchronous active-low reset
//   i_enable       raster run enable; low parks the counters at (0,0)
//   o_x, o_y       scaled column/row of the current pixel (valid with o_req)
//   o_req          current pixel is visible
//   o_line_start   1-clock pulse at h_cnt==0 on a visible line
//   o_frame_start  1-clock pulse at h_cnt==0, v_cnt==0
//   i_red/green/blue  renderer colour, PIPE_LAT clocks after o_req
//   o_red/green/blue  registered pin colour (0 while blanked)
//   o_hsync, o_vsync  registered pin sync at the configured polarity
//   o_frame_cnt    (VGA_FRAME_COUNTER_EN only) frames started, wraps at 16 bits
//
// Renderer handshake: there is no back-pressure. When o_req is high in cycle
// n, the renderer must present the colour for (o_x, o_y) on i_red/i_green/
// i_blue in cycle n+PIPE_LAT; the colour inputs are ignored in cycles whose
// delayed o_req is low.

module vga_timing_pipe #(
    parameter int   H_VISIBLE  = 800,
    parameter int   H_FRONT    = 40,
    parameter int   H_SYNC     = 128,
    parameter int   H_BACK     = 88,
    parameter int   V_VISIBLE  = 600,
    parameter int   V_FRONT    = 1,
    parameter int   V_SYNC     = 4,
    parameter int   V_BACK     = 23,
    parameter logic H_SYNC_POL = 1'b1,
    parameter logic V_SYNC_POL = 1'b1,
    parameter int   SCALE_LOG2 = 2,
    parameter int   PIPE_LAT   = 2,
    parameter int   X_W        = 11,
    parameter int   Y_W        = 10
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_enable,
    output logic [X_W-SCALE_LOG2-1:0] o_x,
    output logic [Y_W-SCALE_LOG2-1:0] o_y,
    output logic                      o_req,
    output logic                      o_line_start,
    output logic                      o_frame_start,
    input  logic [1:0]                i_red,
    input  logic [1:0]                i_green,
    input  logic [1:0]                i_blue,
    output logic [1:0]                o_red,
    output logic [1:0]                o_green,
    output logic [1:0]                o_blue,
    output logic                      o_hsync,
    output logic                      o_vsync
`ifdef VGA_FRAME_COUNTER_EN
    ,
    output logic [15:0]               o_frame_cnt
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > (1 << X_W)) begin : g_bad_h_total
            $error("vga_timing_pipe: H_TOTAL does not fit in X_W bits");
        end
        if (V_TOTAL > (1 << Y_W)) begin : g_bad_v_total
            $error("vga_timing_pipe: V_TOTAL does not fit in Y_W bits");
        end
        if (SCALE_LOG2 > 4 || SCALE_LOG2 < 0) begin : g_bad_scale
            $error("vga_timing_pipe: SCALE_LOG2 must be in 0..4");
        end
    endgenerate

    // Thresholds are one bit wider than the counters because H_TOTAL may
    // equal 2^X_W exactly (and likewise for V).
    localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
    localparam logic [X_W:0]   H_VIS_END  = (X_W+1)'(H_VISIBLE);
    localparam logic [X_W:0]   HS_START   = (X_W+1)'(H_VISIBLE + H_FRONT);
    localparam logic [X_W:0]   HS_END     = (X_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [Y_W:0]   V_VIS_END  = (Y_W+1)'(V_VISIBLE);
    localparam logic [Y_W:0]   VS_START   = (Y_W+1)'(V_VISIBLE + V_FRONT);
    localparam logic [Y_W:0]   VS_END     = (Y_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [X_W-1:0] h_cnt;
    logic [Y_W-1:0] v_cnt;

    // Reset and disable both park the raster at (0,0), so the first running
    // cycle always starts a fresh frame.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Stage 0: decode straight from the counter registers.
    logic         active;
    logic [X_W:0] h_ext;
    logic [Y_W:0] v_ext;
    logic         h_vis;
    logic         v_vis;
    logic         hsync_raw;
    logic         vsync_raw;
    logic [2:0]   stage0;   // {de, hsync_raw, vsync_raw}
    logic [2:0]   delayed;

    assign active    = i_rst_n & i_enable;
    assign h_ext     = {1'b0, h_cnt};
    assign v_ext     = {1'b0, v_cnt};
    assign h_vis     = (h_ext < H_VIS_END);
    assign v_vis     = (v_ext < V_VIS_END);
    assign hsync_raw = (h_ext >= HS_START) && (h_ext < HS_END);
    assign vsync_raw = (v_ext >= VS_START) && (v_ext < VS_END);

    assign o_req         = active & h_vis & v_vis;
    assign o_line_start  = active & (h_cnt == '0) & v_vis;
    assign o_frame_start = active & (h_cnt == '0) & (v_cnt == '0);
    assign o_x           = h_cnt[X_W-1:SCALE_LOG2];
    assign o_y           = v_cnt[Y_W-1:SCALE_LOG2];

    // While stopped, stage 0 is all-inactive so the pins drain to blank.
    assign stage0 = {o_req, active & hsync_raw, active & vsync_raw};

    generate
        if (PIPE_LAT == 0) begin : g_no_pipe
            assign delayed = stage0;
        end else begin : g_pipe
            logic [2:0] pipe [PIPE_LAT];

            // Reset clears every stage so no partial sync pulse survives.
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= stage0;
                    for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign delayed = pipe[PIPE_LAT-1];
        end
    endgenerate

    // Pin register: colour gated by delayed de, sync mapped to pin polarity.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_red   <= 2'b00;
            o_green <= 2'b00;
            o_blue  <= 2'b00;
            o_hsync <= ~H_SYNC_POL;
            o_vsync <= ~V_SYNC_POL;
        end else begin
            o_red   <= delayed[2] ? i_red   : 2'b00;
            o_green <= delayed[2] ? i_green : 2'b00;
            o_blue  <= delayed[2] ? i_blue  : 2'b00;
            o_hsync <= delayed[1] ? H_SYNC_POL : ~H_SYNC_POL;
            o_vsync <= delayed[0] ? V_SYNC_POL : ~V_SYNC_POL;
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    // o_frame_start is already low while disabled, so the count holds then.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_frame_cnt <= 16'h0000;
        end else if (o_frame_start) begin
            o_frame_cnt <= o_frame_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb_vga_timing_pipe
//   Bench for vga_timing_pipe on a small raster (16 clocks x 8 lines) whose
//   totals exactly fill the counter widths. The driver issues randomized
//   reset/enable/colour stimulus and pushes expected responses computed from
//   a raster position model; a monitor on the falling edge pops and compares.

module tb_vga_timing_pipe;

    localparam int   HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int   VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int   HT = HV + HF + HS + HB;
    localparam int   VT = VV + VF + VS + VB;
    localparam int   SC = 1;
    localparam int   LAT = 2;
    localparam int   XW = 4;
    localparam int   YW = 3;
    localparam logic HPOL = 1'b0;
    localparam logic VPOL = 1'b1;
    localparam int   N_CYCLES = 4000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic [1:0]       in_red = 2'b00, in_green = 2'b00, in_blue = 2'b00;
    logic [XW-SC-1:0] x;
    logic [YW-SC-1:0] y;
    logic             req, line_start, frame_start;
    logic [1:0]       red, green, blue;
    logic             hsync, vsync;
`ifdef VGA_FRAME_COUNTER_EN
    logic [15:0]      frame_cnt;
`endif

    vga_timing_pipe #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL),
        .SCALE_LOG2(SC), .PIPE_LAT(LAT), .X_W(XW), .Y_W(YW)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_enable(enable),
        .o_x(x),
        .o_y(y),
        .o_req(req),
        .o_line_start(line_start),
        .o_frame_start(frame_start),
        .i_red(in_red),
        .i_green(in_green),
        .i_blue(in_blue),
        .o_red(red),
        .o_green(green),
        .o_blue(blue),
        .o_hsync(hsync),
        .o_vsync(vsync)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .o_frame_cnt(frame_cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    logic [7:0]  comb_q[$];  // {req, line_start, frame_start, x[2:0], y[1:0]}
    logic [7:0]  pin_q[$];   // {red, green, blue, hsync, vsync}
    logic [15:0] fc_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // ---------------- reference model state ----------------
    int          pos = 0;          // position in frame, 0 .. HT*VT-1
    logic [2:0]  hist[$];          // past {de, hs, vs}, oldest first
    int          fc_model = 0;

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic r, input logic e);
        int h, v;
        logic act, de, hs_raw, vs_raw;
        logic [2:0] s, d;
        logic [7:0] pv;
        rst_n    = r;
        enable   = e;
        in_red   = 2'($urandom_range(0, 3));
        in_green = 2'($urandom_range(0, 3));
        in_blue  = 2'($urandom_range(0, 3));

        h   = pos % HT;
        v   = pos / HT;
        act = r && e;
        de  = act && (h < HV) && (v < VV);
        hs_raw = act && (h >= HV + HF) && (h < HV + HF + HS);
        vs_raw = act && (v >= VV + VF) && (v < VV + VF + VS);
        comb_q.push_back({de, act && (h == 0) && (v < VV), act && (pos == 0),
                          3'(h >> SC), 2'(v >> SC)});
        fc_q.push_back(16'(fc_model));

        s = {de, hs_raw, vs_raw};
        d = (LAT == 0) ? s : hist[0];
        if (!r)
            pv = {6'b0, ~HPOL, ~VPOL};
        else
            pv = {d[2] ? in_red : 2'b00, d[2] ? in_green : 2'b00,
                  d[2] ? in_blue : 2'b00,
                  d[1] ? HPOL : ~HPOL, d[0] ? VPOL : ~VPOL};
        pin_q.push_back(pv);

        if (!r) fc_model = 0;
        else if (act && pos == 0) fc_model = (fc_model + 1) % 65536;

        if (!r) begin
            hist.delete();
            for (int i = 0; i < LAT; i++) hist.push_back(3'b000);
        end else if (LAT > 0) begin
            hist.push_back(s);
            void'(hist.pop_front());
        end

        pos = act ? (pos + 1) % (HT * VT) : 0;
    endtask

    initial begin
        int en_hold;
        logic en_rand, r;
        for (int i = 0; i < LAT; i++) hist.push_back(3'b000);
        en_hold = 0;
        en_rand = 1'b1;
        for (int n = 1; n <= N_CYCLES; n++) begin
            @(posedge clk);
            #1;
            if (n <= 3) begin
                drive_cycle(1'b0, 1'b0);
            end else if (n <= 600) begin
                // several uninterrupted frames, including the frame wrap
                drive_cycle(1'b1, 1'b1);
            end else if (n == 700 || n == 1500) begin
                // mid-frame reset pulse
                drive_cycle(1'b0, 1'b1);
            end else if (n >= 1000 && n < 1130) begin
                // one frame with the raster stopped
                drive_cycle(1'b1, 1'b0);
            end else if (n < 1200) begin
                drive_cycle(1'b1, 1'b1);
            end else begin
                if (en_hold == 0) begin
                    en_rand = ($urandom_range(0, 9) != 0);
                    en_hold = $urandom_range(1, 200);
                end
                en_hold--;
                r = ($urandom_range(0, 249) != 0);
                drive_cycle(r, en_rand);
            end
        end
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [7:0] e;
        logic [7:0] p;
        logic [15:0] f;
        if (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            check("o_req", int'(req), int'(e[7]));
            check("o_line_start", int'(line_start), int'(e[6]));
            check("o_frame_start", int'(frame_start), int'(e[5]));
            if (e[7]) begin
                check("o_x", int'(x), int'(e[4:2]));
                check("o_y", int'(y), int'(e[1:0]));
            end
        end
        // head of pin_q holds the expectation issued one cycle earlier
        if (pin_q.size() >= 2) begin
            p = pin_q.pop_front();
            check("o_red", int'(red), int'(p[7:6]));
            check("o_green", int'(green), int'(p[5:4]));
            check("o_blue", int'(blue), int'(p[3:2]));
            check("o_hsync", int'(hsync), int'(p[1]));
            check("o_vsync", int'(vsync), int'(p[0]));
        end
        if (fc_q.size() > 0) begin
            f = fc_q.pop_front();
`ifdef VGA_FRAME_COUNTER_EN
            check("o_frame_cnt", int'(frame_cnt), int'(f));
`endif
        end
    end

endmodule

// File: doc/vga_timing_pipe.md
Name: vga_timing_pipe

Overview:
Parametrised VGA raster timing generator with a latency-matched pixel pipeline. It replaces the fixed 800x600 hard-coded counter and sync logic with configurable timing, sync polarity, pixel downscaling and renderer latency. It issues scaled pixel coordinates to a downstream renderer (font ROM, framebuffer) and accepts colour back a fixed number of cycles later. It delays sync and blanking by the same amount so colour and sync reach the DAC pins aligned.

Parameters:
- H_VISIBLE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch (clocks)
- H_SYNC, 128, horizontal sync pulse width
- H_BACK, 88, horizontal back porch
- V_VISIBLE, 600, visible lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BACK, 23, vertical back porch (lines)
- H_SYNC_POL, 1, active level of o_hsync
- V_SYNC_POL, 1, active level of o_vsync
- SCALE_LOG2, 2, coordinate downscale; o_x = h_cnt >> SCALE_LOG2; legal range 0..4
- PIPE_LAT, 2, renderer latency in clocks from o_req to i_red/i_green/i_blue; 0 is legal
- X_W, 11, width of h counter; Y_W, 10, width of v counter

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  synchronous active-low reset
- i_enable  in  1  raster run enable
- o_x  out  X_W-SCALE_LOG2  scaled column of current pixel
- o_y  out  Y_W-SCALE_LOG2  scaled row of current pixel
- o_req  out  1  current pixel is visible; renderer must answer PIPE_LAT clocks later
- o_line_start  out  1  1-clock pulse at h_cnt==0 on a visible line
- o_frame_start  out  1  1-clock pulse at h_cnt==0, v_cnt==0
- i_red, i_green, i_blue  in  2 each  renderer colour, valid PIPE_LAT clocks after o_req
- o_red, o_green, o_blue  out  2 each  registered pin colour
- o_hsync, o_vsync  out  1  registered pin sync

Behaviour:
- Line order: visible, front porch, sync, back porch. H_TOTAL = sum of H params, V_TOTAL likewise.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments on the h wrap and wraps after V_TOTAL-1.
- Stage 0 is decoded from the counter registers. o_req = (h_cnt<H_VISIBLE)&&(v_cnt<V_VISIBLE). o_x and o_y are always driven, and are meaningful only while o_req is high.
- hsync_raw is active for H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC. vsync_raw uses the same rule on v_cnt.
- A PIPE_LAT-deep shift register carries {de, hsync_raw, vsync_raw}.
- Output register: o_red/o_green/o_blue = de_delayed ? i_colour : 0. o_hsync/o_vsync are the delayed raw sync driven at the polarity-corrected level.
- Total latency from counter state to pins is PIPE_LAT+1 clocks.
- Reset (i_rst_n low at a clock edge):
  - h_cnt, v_cnt = 0.
  - Delay line filled with inactive entries.
  - Next cycle: colour outputs 0, o_hsync = ~H_SYNC_POL, o_vsync = ~V_SYNC_POL.
  - o_req, o_line_start and o_frame_start are forced 0 while reset is asserted.
  - Reset mid-frame restarts the raster at (0,0) immediately, with no partial sync pulse left in the pipe.
- i_enable low:
  - Counters load 0 on the next edge and hold there.
  - o_req, o_line_start and o_frame_start are 0.
  - The delay line keeps shifting inactive entries, so pins blank and de-assert sync within PIPE_LAT+1 clocks.
  - On the first enabled cycle, counters are at (0,0) and o_frame_start pulses.
- Simultaneous h and v wrap (last clock of the frame): both counters go to 0 in the same edge, and o_frame_start asserts on the following cycle.
- Elaboration must fail (generate error) if H_TOTAL > 2^X_W, V_TOTAL > 2^Y_W, or SCALE_LOG2 > 4.

Optional Feature:
- Macro VGA_FRAME_COUNTER_EN.
- Defined: adds port o_frame_cnt (out, 16 bits). It resets to 0, increments by 1 on each cycle o_frame_start is high, and wraps 0xFFFF -> 0x0000. It is held while i_enable is low.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Small raster H=8/2/3/3, V=4/1/2/1, SCALE_LOG2=0, PIPE_LAT=2, renderer returns i_green=h-derived constant 2'b11 -> o_req high 8 of every 16 clocks on lines 0..3. o_hsync active (1) for h_cnt 10..12, appearing at pins 3 clocks later. o_green=2'b11 exactly during delayed de.
- Same config, count clocks between o_frame_start pulses -> exactly 128. o_vsync active for 2 lines (32 clocks) starting at line 5, +3 clock pin offset.
- H_SYNC_POL=0, V_SYNC_POL=0 -> pins idle high after reset and pulse low at the same positions as the first test.
- SCALE_LOG2=2, default 800x600 timing -> o_x steps 0..199, changing every 4 clocks. o_y steps 0..149, changing every 4 lines. o_line_start fires 600 times per frame.
- Assert i_rst_n=0 for 1 clock at h_cnt=300, v_cnt=200 -> next cycle counters (0,0). Pins show inactive sync and zero colour. o_frame_start pulses on the first cycle after release.
- With VGA_FRAME_COUNTER_EN: preload via forced counter to 0xFFFE, run 3 frames -> o_frame_cnt sequence 0xFFFF, 0x0000, 0x0001. Drop i_enable for 1 frame -> value holds.
